// File: rtl/secp256k1_addsub_mod_serial_param_pkg.sv
// Shared definitions for the secp256k1 word-serial field arithmetic units:
// the field prime, operation encodings, controller states and word-count helper.
package secp256k1_pkg;

    localparam logic [255:0] SECP_P =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_CORR,
        ST_DONE
    } addsub_state_t;

    function automatic int nw(input int field_w, input int word_w);
        return field_w / word_w;
    endfunction

endpackage

// File: rtl/secp256k1_addsub_mod_serial_param_if.sv
// Request/response bundle of the serial mod-p add/sub unit.
interface secp256k1_addsub_mod_serial_param_if #(
    parameter int FIELD_W = 256
);
    logic               start;
    logic               op;
    logic [FIELD_W-1:0] a;
    logic [FIELD_W-1:0] b;
    logic               busy;
    logic               done;
    logic [FIELD_W-1:0] result;

    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/secp256k1_addsub_mod_serial_param_word.sv
// One WORD_W-bit add/sub slice with carry/borrow in and out; cout is the
// carry for add and the borrow for sub.
module modarith_word_addsub #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic              cin,
    input  logic              sub,
    output logic [WORD_W-1:0] s,
    output logic              cout
);
    logic [WORD_W:0] r;

    always_comb begin
        if (sub) r = {1'b0, x} - {1'b0, y} - {{WORD_W{1'b0}}, cin};
        else     r = {1'b0, x} + {1'b0, y} + {{WORD_W{1'b0}}, cin};
    end

    assign s    = r[WORD_W-1:0];
    assign cout = r[WORD_W];
endmodule

// File: rtl/secp256k1_addsub_mod_serial_param.sv
// Word-serial (a +/- b) mod P: one pass forms the raw sum/difference, a second
// pass forms the P-corrected value, and the final carry/borrow bits pick one.
module secp256k1_addsub_mod_serial_param
    import secp256k1_pkg::*;
#(
    parameter int                 WORD_W  = 32,
    parameter int                 FIELD_W = 256,
    parameter logic [FIELD_W-1:0] MODULUS = SECP_P
) (
    input logic clk,
    input logic rst,
    secp256k1_addsub_mod_serial_param_if.slave bus
);
    localparam int NW    = nw(FIELD_W, WORD_W);
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;

    addsub_state_t      state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               chain_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;
    logic [FIELD_W-1:0] result_q;

    logic [FIELD_W-1:0] a_q;
    logic [FIELD_W-1:0] b_q;
    logic               op_q;
    logic [WORD_W-1:0]  s_bank_q [NW];
    logic [WORD_W-1:0]  t_bank_q [NW];

    logic [WORD_W-1:0]  a_word [NW];
    logic [WORD_W-1:0]  b_word [NW];
    logic [WORD_W-1:0]  p_word [NW];
    logic [FIELD_W-1:0] s_flat;
    logic [FIELD_W-1:0] t_flat;

    for (genvar g = 0; g < NW; g++) begin : g_words
        assign a_word[g] = a_q[g*WORD_W +: WORD_W];
        assign b_word[g] = b_q[g*WORD_W +: WORD_W];
        assign p_word[g] = MODULUS[g*WORD_W +: WORD_W];
        assign s_flat[g*WORD_W +: WORD_W] = s_bank_q[g];
        assign t_flat[g*WORD_W +: WORD_W] = t_bank_q[g];
    end

    logic [WORD_W-1:0] x_w, y_w, s_w;
    logic              sub_w, cout_w, last_w;

    // The correction pass undoes the first op: add then subtracts P, sub adds P back.
    always_comb begin
        x_w   = a_word[idx_q];
        y_w   = b_word[idx_q];
        sub_w = (op_q == OP_SUB);
        if (state_q == ST_CORR) begin
            x_w   = s_bank_q[idx_q];
            y_w   = p_word[idx_q];
            sub_w = (op_q == OP_ADD);
        end
    end

    assign last_w = (idx_q == IDX_W'(NW - 1));

    modarith_word_addsub #(.WORD_W(WORD_W)) u_word (
        .x    (x_w),
        .y    (y_w),
        .cin  (chain_q),
        .sub  (sub_w),
        .s    (s_w),
        .cout (cout_w)
    );

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && bus.start) begin
            a_q  <= bus.a;
            b_q  <= bus.b;
            op_q <= bus.op;
        end
        if (state_q == ST_ACC)  s_bank_q[idx_q] <= s_w;
        if (state_q == ST_CORR) t_bank_q[idx_q] <= s_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            chain_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        idx_q   <= '0;
                        chain_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (last_w) begin
                        ovf_q   <= cout_w;
                        chain_q <= 1'b0;
                        idx_q   <= '0;
                        state_q <= ST_CORR;
                    end else begin
                        chain_q <= cout_w;
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end
                ST_CORR: begin
                    chain_q <= cout_w;
                    if (last_w) begin
                        idx_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // Add keeps the raw sum only if it neither overflowed nor reached P.
                    if (op_q == OP_ADD) result_q <= (ovf_q || !chain_q) ? t_flat : s_flat;
                    else                result_q <= ovf_q ? t_flat : s_flat;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_secp256k1_addsub_mod_serial_param.sv
// Directed bench for the serial mod-p add/sub unit at WORD_W = 32, 64 and 8.
module tb_secp256k1_addsub_mod_serial_param;

    localparam logic [255:0] P =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    secp256k1_addsub_mod_serial_param_if #(.FIELD_W(256)) if0 ();
    secp256k1_addsub_mod_serial_param_if #(.FIELD_W(256)) if1 ();
    secp256k1_addsub_mod_serial_param_if #(.FIELD_W(256)) if2 ();

    secp256k1_addsub_mod_serial_param #(.WORD_W(32), .FIELD_W(256)) dut32 (.clk(clk), .rst(rst), .bus(if0));
    secp256k1_addsub_mod_serial_param #(.WORD_W(64), .FIELD_W(256)) dut64 (.clk(clk), .rst(rst), .bus(if1));
    secp256k1_addsub_mod_serial_param #(.WORD_W(8),  .FIELD_W(256)) dut8  (.clk(clk), .rst(rst), .bus(if2));

    int           sel = 0;
    logic         start_v = 1'b0;
    logic         op_v = 1'b0;
    logic [255:0] a_v = '0;
    logic [255:0] b_v = '0;

    assign if0.start = start_v && (sel == 0);
    assign if1.start = start_v && (sel == 1);
    assign if2.start = start_v && (sel == 2);
    assign if0.op = op_v;  assign if0.a = a_v;  assign if0.b = b_v;
    assign if1.op = op_v;  assign if1.a = a_v;  assign if1.b = b_v;
    assign if2.op = op_v;  assign if2.a = a_v;  assign if2.b = b_v;

    logic         m_busy, m_done;
    logic [255:0] m_res;
    always_comb begin
        case (sel)
            1:       begin m_busy = if1.busy; m_done = if1.done; m_res = if1.result; end
            2:       begin m_busy = if2.busy; m_done = if2.done; m_res = if2.result; end
            default: begin m_busy = if0.busy; m_done = if0.done; m_res = if0.result; end
        endcase
    end

    int lat [3] = '{17, 9, 65};
    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic         op;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input int s, input logic o, input logic [255:0] av, input logic [255:0] bv);
        @(negedge clk);
        sel = s; op_v = o; a_v = av; b_v = bv; start_v = 1'b1;
        @(posedge clk);
        #1 start_v = 1'b0;
    endtask

    // Counts edges after the accept edge until done; optionally injects a start pulse.
    task automatic wait_done(input int inj, output int cnt, output logic busy_ok);
        cnt = 0;
        busy_ok = 1'b1;
        while (cnt < 300) begin
            @(posedge clk);
            #1 cnt++;
            if (m_done) begin
                if (m_busy) busy_ok = 1'b0;
                break;
            end
            if (!m_busy) busy_ok = 1'b0;
            if (cnt == inj) begin
                start_v = 1'b1; op_v = 1'b1; a_v = 256'd100; b_v = 256'd1;
            end else if (cnt == inj + 1) begin
                start_v = 1'b0;
            end
        end
    endtask

    initial begin
        int   cnt, cnt2;
        logic bok, seen;

        vecs[0] = '{1'b0, P - 256'd1, 256'd1, 256'd0};
        vecs[1] = '{1'b0, P - 256'd1, P - 256'd1,
                    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2D};
        vecs[2] = '{1'b0, 256'd5, 256'd7, 256'd12};
        vecs[3] = '{1'b1, 256'd3, 256'd5,
                    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2D};
        vecs[4] = '{1'b1, 256'h1234, 256'h1234, 256'd0};
        vecs[5] = '{1'b1, P - 256'd1, 256'd0,
                    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2E};
        vecs[6] = '{1'b0, 256'hFFFFFFFFFFFFFFFF, 256'd1, 256'h1_0000_0000_0000_0000};
        vecs[7] = '{1'b1, 256'h1_0000_0000_0000_0000, 256'd1, 256'hFFFFFFFFFFFFFFFF};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("rst_busy_%0d", s), {255'd0, m_busy}, 256'd0);
            chk($sformatf("rst_done_%0d", s), {255'd0, m_done}, 256'd0);
            chk($sformatf("rst_result_%0d", s), m_res, 256'd0);
        end
        rst = 1'b0;

        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 8; i++) begin
                issue(s, vecs[i].op, vecs[i].a, vecs[i].b);
                wait_done(-1, cnt, bok);
                chk($sformatf("w%0d_v%0d_result", s, i), m_res, vecs[i].exp);
                chk($sformatf("w%0d_v%0d_latency", s, i), 256'(cnt), 256'(lat[s]));
                chk($sformatf("w%0d_v%0d_busy", s, i), {255'd0, bok}, 256'd1);
            end
        end

        // Start pulse while busy is ignored; a sub issued in the done cycle is accepted.
        issue(0, 1'b0, 256'd5, 256'd7);
        wait_done(3, cnt, bok);
        chk("ignore_result", m_res, 256'd12);
        chk("ignore_latency", 256'(cnt), 256'd17);
        start_v = 1'b1; op_v = 1'b1; a_v = 256'd3; b_v = 256'd5;
        @(posedge clk);
        #1 start_v = 1'b0;
        chk("done_pulse_width", {255'd0, m_done}, 256'd0);
        chk("b2b_busy", {255'd0, m_busy}, 256'd1);
        wait_done(-1, cnt2, bok);
        chk("b2b_result", m_res, vecs[3].exp);
        chk("b2b_gap", 256'(cnt2 + 1), 256'd18);

        // Reset sampled at ACC word 3 aborts the operation.
        issue(0, 1'b0, P - 256'd1, 256'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_busy", {255'd0, m_busy}, 256'd0);
        chk("abort_done", {255'd0, m_done}, 256'd0);
        chk("abort_result", m_res, 256'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (m_done) seen = 1'b1;
        end
        chk("abort_no_done", {255'd0, seen}, 256'd0);
        issue(0, 1'b0, 256'd5, 256'd7);
        wait_done(-1, cnt, bok);
        chk("after_abort_result", m_res, 256'd12);
        chk("after_abort_latency", 256'(cnt), 256'd17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/secp256k1_addsub_mod_serial_param.md
Name: secp256k1_addsub_mod_serial_param

Overview:
- Word-serial modular adder/subtractor for the secp256k1 field, with add/sub selected per operation by `op`.
- Successor to the fixed 32-bit-word serial add and serial sub units. Generalised in word width, field width and modulus.
- Fixed, data-independent latency. No MSB-first compare pass.
- Used by the area-optimised point-arithmetic datapath wherever a mod-p add or sub is issued.

Parameters:
- WORD_W, 32, datapath word width in bits. Legal values: 8, 16, 32, 64.
- FIELD_W, 256, operand width in bits. Must be a multiple of WORD_W.
- MODULUS, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F, modulus P. P is odd, P < 2^FIELD_W, and P[FIELD_W-1] = 1.
- NW (localparam), FIELD_W/WORD_W, word count. Index counter width is max(1, $clog2(NW)).

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request. Accepted only when busy=0.
- op  in  1  0 = (a+b) mod P, 1 = (a-b) mod P. Sampled with start.
- a  in  FIELD_W  operand. Must be < P.
- b  in  FIELD_W  operand. Must be < P.
- busy  out  1  high from the accept edge until the done edge.
- done  out  1  one-cycle pulse; result is valid from this cycle onward.
- result  out  FIELD_W  reduced result in [0, P). Held until the next done.

Behaviour:
- Reset: rst is sampled at posedge clk.
  - Outputs: done=0, busy=0, result=0, state=IDLE.
  - Counter and carry/borrow are cleared.
  - rst mid-operation aborts the operation. No done is produced; busy=0 after the reset edge.
- Operand capture: a, b and op are captured into internal registers at the accept edge. Inputs may change freely afterwards.
- States and timing (edge 0 = start sampled high in IDLE):
  - IDLE: on start, capture operands, clear idx and carry, go to ACC, busy<=1.
  - ACC, edges 1..NW, word idx LSW first:
    - op=0: S[idx] = a[idx] + b[idx] + c.
    - op=1: D[idx] = a[idx] - b[idx] - bw.
    - Store the word and update carry/borrow.
    - After the last word, latch the final carry/borrow as `ovf`. Clear the chain bit, idx=0, go to CORR.
  - CORR, edges NW+1..2NW:
    - Compute T[idx] = S[idx] - P[idx] - bw (add), or T[idx] = D[idx] + P[idx] + c (sub).
    - Store T in a second word bank and propagate the chain bit.
    - After the last word, go to DONE.
  - DONE, edge 2NW+1: select the result, set done<=1, busy<=0, go to IDLE.
    - Add: result = (ovf=1 or final borrow=0) ? T : S.
    - Sub: result = ovf ? T : D.
  - IDLE, edge 2NW+2: done<=0.
- Latency: done is high exactly 2NW+1 edges after the accept edge. That is 17 for the default and 9 for WORD_W=64. Latency does not depend on data.
- Throughput:
  - start while busy=1 is ignored; no queueing and no error.
  - start may be high in the done cycle and is accepted at the next edge. Back-to-back issue costs 2NW+2 cycles.
- Arithmetic:
  - All word ops are WORD_W+1 bits wide; the MSB is the carry or borrow.
  - Results are exact modulo P for inputs < P, including sum == P, which gives 0.
  - Inputs >= P give an unspecified value; the bench does not check this case.
- Registers: all registers are synchronous. There is no asynchronous reset anywhere.

Decomposition:
- Shared package `secp256k1_pkg`:
  - SECP_P, the 256-bit prime.
  - OP_ADD=1'b0 and OP_SUB=1'b1.
  - A function nw(field_w, word_w).
- One combinational sub-module, `modarith_word_addsub`, parametrised by WORD_W.
  - Inputs: x, y, cin, sub.
  - Outputs: s, cout. cout is the carry for add and the borrow for sub.
  - Instantiated once and shared by ACC and CORR through operand muxing.
- Word banks are indexed register arrays. The P word is selected by part-select of MODULUS at idx.

Test Plan:
1. op=0, a=P-1, b=1: result=0, done exactly 17 clocks after the accept edge, busy high for edges 1..17.
2. op=0, a=b=P-1 (carry-out path): result=P-2=…FFFFFFFEFFFFFC2D. op=0, a=5, b=7: result=12, uncorrected path.
3. op=1, a=3, b=5: result=P-2. op=1, a=b=0x1234: result=0. op=1, a=P-1, b=0: result=P-1.
4. Back-to-back and busy handling:
   - Start an add, and pulse start with different operands while busy: the pulse is ignored and the first result is correct.
   - Issue a sub in the done cycle: it is accepted, and its done arrives 18 cycles after the first done.
5. Reset abort: assert rst for 1 cycle during ACC word 3.
   - Next cycle: busy=0, done=0, result=0, and no done pulse follows.
   - A subsequent op=0 with a=5, b=7 gives 12 at the nominal latency.
6. WORD_W=64 and WORD_W=8 instances: rerun scenarios 1–3. Results are identical; latency is 9 and 65 edges respectively.
